// File: rtl/cnn_och_sched_if.sv
// Signal bundle between the output-channel scheduler and its weight memory,
// accumulator and output buffer. The master side is the scheduler.
interface cnn_och_sched_if #(
    parameter int unsigned OCH   = 4,
    parameter int unsigned OUT_W = 288,
    parameter int unsigned WT_W  = 288
);
    localparam int unsigned IDX_W = (OCH > 1) ? $clog2(OCH) : 1;

    logic             i_start;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic             o_wt_rd_en;
    logic [IDX_W-1:0] o_wt_rd_addr;
    logic [WT_W-1:0]  i_wt_rd_data;
    logic [WT_W-1:0]  o_acc_weight;
    logic             o_acc_soft_reset;
    logic             o_acc_in_valid;
    logic             i_acc_ot_valid;
    logic [OUT_W-1:0] i_acc_ci_acc;
    logic             o_ot_valid;
    logic             i_ot_ready;
    logic [IDX_W-1:0] o_ot_och;
    logic [OUT_W-1:0] o_ot_data;

    modport master (
        input  i_start, i_wt_rd_data, i_acc_ot_valid, i_acc_ci_acc, i_ot_ready,
        output o_busy, o_done, o_err, o_wt_rd_en, o_wt_rd_addr, o_acc_weight,
               o_acc_soft_reset, o_acc_in_valid, o_ot_valid, o_ot_och, o_ot_data
    );

    modport slave (
        output i_start, i_wt_rd_data, i_acc_ot_valid, i_acc_ci_acc, i_ot_ready,
        input  o_busy, o_done, o_err, o_wt_rd_en, o_wt_rd_addr, o_acc_weight,
               o_acc_soft_reset, o_acc_in_valid, o_ot_valid, o_ot_och, o_ot_data
    );
endinterface

// File: rtl/cnn_och_sched.sv
// Sequences one accumulator pass per output channel: clear, fetch weights,
// issue, wait for the result (with timeout) and hand it to the output buffer.
module cnn_och_sched #(
    parameter int unsigned OCH     = 4,
    parameter int unsigned OUT_W   = 288,
    parameter int unsigned WT_W    = 288,
    parameter int unsigned TIMEOUT = 64
) (
    input logic             clk,
    input logic             reset,
    cnn_och_sched_if.master bus
);
    localparam int unsigned IDX_W = (OCH > 1) ? $clog2(OCH) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OCH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, CLR, FETCH, LATCH, ISSUE, WAIT, OUT, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err, err_nxt;
    logic [WT_W-1:0]  acc_weight, acc_weight_nxt;
    logic [OUT_W-1:0] ot_data, ot_data_nxt;
    logic [IDX_W-1:0] ot_och, ot_och_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            acc_weight <= '0;
            ot_data    <= '0;
            ot_och     <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            err        <= err_nxt;
            acc_weight <= acc_weight_nxt;
            ot_data    <= ot_data_nxt;
            ot_och     <= ot_och_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cnt_nxt        = cnt;
        err_nxt        = err;
        acc_weight_nxt = acc_weight;
        ot_data_nxt    = ot_data;
        ot_och_nxt     = ot_och;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nxt = CLR;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            CLR:   state_nxt = FETCH;
            FETCH: state_nxt = LATCH;
            LATCH: begin
                acc_weight_nxt = bus.i_wt_rd_data;
                state_nxt      = ISSUE;
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.i_acc_ot_valid) begin
                    ot_data_nxt = bus.i_acc_ci_acc;
                    ot_och_nxt  = idx;
                    state_nxt   = OUT;
                end else if (cnt == CNT_LAST) begin
                    // Timeout abandons the remaining channels for this run.
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            OUT: begin
                if (bus.i_ot_ready) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = CLR;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy           = (state != IDLE);
        bus.o_done           = (state == DONE);
        bus.o_err            = err;
        bus.o_wt_rd_en       = (state == FETCH);
        bus.o_wt_rd_addr     = idx;
        bus.o_acc_weight     = acc_weight;
        bus.o_acc_soft_reset = (state == CLR);
        bus.o_acc_in_valid   = (state == ISSUE);
        bus.o_ot_valid       = (state == OUT);
        bus.o_ot_och         = ot_och;
        bus.o_ot_data        = ot_data;
    end
endmodule

// File: tb/tb_cnn_och_sched.sv
// Randomized bench for cnn_och_sched: memory/accumulator/output-buffer models
// drive the DUT and each run is checked against a run-level expectation.
module tb_cnn_och_sched;
    localparam int unsigned OCH     = 4;
    localparam int unsigned OUT_W   = 288;
    localparam int unsigned WT_W    = 288;
    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnn_och_sched_if #(.OCH(OCH), .OUT_W(OUT_W), .WT_W(WT_W)) bus ();

    cnn_och_sched #(
        .OCH(OCH), .OUT_W(OUT_W), .WT_W(WT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [287:0] rnd288();
        logic [287:0] v;
        for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Run configuration, written only by the sequencer.
    logic [WT_W-1:0]  mem  [OCH];
    logic [OUT_W-1:0] resp [OCH];
    int unsigned lat        = 3;
    int          mute_ch    = -1;
    int          ready_mode = 0;
    bit          strays     = 1'b0;

    // Model/monitor state, written only by the negedge process.
    int unsigned cyc = 0, acc_cnt = 0, stall_left = 0;
    int acc_ch = 0, exp_ch = 0;
    int fetch_cnt = 0, clr_cnt = 0, iss_cnt = 0, done_cnt = 0, stall_cnt = 0;
    int start_cyc = 0, done_cyc = 0;
    bit prev_busy = 0, prev_sr = 0, prev_iv = 0, prev_ov = 0, prev_rdy = 0, prev_hs = 0, prev_rd = 0;
    logic [OUT_W-1:0] held_data;
    logic [1:0]       held_och;
    int               got_och[$];
    logic [OUT_W-1:0] got_data[$];

    always @(negedge clk) begin
        cyc++;
        // Per-run statistics restart when the scheduler leaves IDLE.
        if (bus.o_busy && !prev_busy) begin
            start_cyc = cyc; exp_ch = 0; fetch_cnt = 0; clr_cnt = 0; iss_cnt = 0;
            done_cnt = 0; stall_cnt = 0; stall_left = 5;
            got_och.delete(); got_data.delete();
        end

        // Weight memory: data appears after the strobe and holds through the next cycle.
        if (bus.o_wt_rd_en) begin
            acc_ch = int'(bus.o_wt_rd_addr);
            bus.i_wt_rd_data = mem[bus.o_wt_rd_addr];
        end else if (!prev_rd) begin
            bus.i_wt_rd_data = rnd288();
        end
        prev_rd = bus.o_wt_rd_en;

        // Accumulator: answers lat cycles after the cycle following the issue pulse.
        bus.i_acc_ot_valid = 1'b0;
        if (acc_cnt != 0) begin
            acc_cnt--;
            if (acc_cnt == 0) begin
                bus.i_acc_ot_valid = 1'b1;
                bus.i_acc_ci_acc   = resp[acc_ch];
            end
        end else if (strays && !bus.o_acc_in_valid && $urandom_range(0, 5) == 0) begin
            bus.i_acc_ot_valid = 1'b1;
            bus.i_acc_ci_acc   = rnd288();
        end
        if (bus.o_acc_in_valid && acc_ch != mute_ch) acc_cnt = lat + 1;

        // Output buffer readiness.
        case (ready_mode)
            1: bus.i_ot_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (bus.o_ot_valid && exp_ch == 1 && stall_left != 0) begin
                    bus.i_ot_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.i_ot_ready = 1'b1;
                end
            end
            default: bus.i_ot_ready = 1'b1;
        endcase

        if (bus.o_wt_rd_en) begin
            fetch_cnt++;
            check("rd_addr", bus.o_wt_rd_addr, exp_ch);
        end
        if (bus.o_acc_soft_reset) begin
            clr_cnt++;
            check("clr_pulse", prev_sr, 0);
            if (clr_cnt > 1) check("clr_after_hs", prev_hs, 1);
        end
        if (bus.o_acc_in_valid) begin
            iss_cnt++;
            check("iss_pulse", prev_iv, 0);
            check("acc_weight", bus.o_acc_weight, mem[exp_ch]);
        end
        if (bus.o_ot_valid) begin
            if (prev_ov && !prev_rdy) begin
                check("hold_data", bus.o_ot_data, held_data);
                check("hold_och", bus.o_ot_och, held_och);
            end
            held_data = bus.o_ot_data;
            held_och  = bus.o_ot_och;
            if (!bus.i_ot_ready) begin
                stall_cnt++;
            end else begin
                got_och.push_back(int'(bus.o_ot_och));
                got_data.push_back(bus.o_ot_data);
                exp_ch++;
            end
        end
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_busy = bus.o_busy;
        prev_sr   = bus.o_acc_soft_reset;
        prev_iv   = bus.o_acc_in_valid;
        prev_ov   = bus.o_ot_valid;
        prev_rdy  = bus.i_ot_ready;
        prev_hs   = bus.o_ot_valid && bus.i_ot_ready;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_done"}, bus.o_done, 0);
        check({tag, "_err"}, bus.o_err, 0);
        check({tag, "_rd_en"}, bus.o_wt_rd_en, 0);
        check({tag, "_rd_addr"}, bus.o_wt_rd_addr, 0);
        check({tag, "_weight"}, bus.o_acc_weight, 0);
        check({tag, "_sreset"}, bus.o_acc_soft_reset, 0);
        check({tag, "_in_valid"}, bus.o_acc_in_valid, 0);
        check({tag, "_ot_valid"}, bus.o_ot_valid, 0);
        check({tag, "_ot_och"}, bus.o_ot_och, 0);
        check({tag, "_ot_data"}, bus.o_ot_data, 0);
    endtask

    task automatic randomize_data(input bit directed);
        for (int i = 0; i < int'(OCH); i++) begin
            mem[i]  = rnd288();
            resp[i] = directed ? 288'(16 + i) : rnd288();
        end
    endtask

    task automatic start_run();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("start_busy", bus.o_busy, 1);
        check("start_err_clr", bus.o_err, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt, 1);
    endtask

    // Reference: channels 0..n-1 complete in order, each costing 6+lat cycles plus
    // imposed stalls; a timeout costs CLR..ISSUE plus TIMEOUT waits; DONE adds one.
    task automatic verify_run(input string tag);
        int n_exp   = (mute_ch < 0) ? int'(OCH) : mute_ch;
        int n_pass  = (mute_ch < 0) ? int'(OCH) : mute_ch + 1;
        int exp_cyc = n_exp * (6 + int'(lat)) + stall_cnt + 1 + ((mute_ch < 0) ? 0 : 4 + int'(TIMEOUT));
        check({tag, "_err"}, bus.o_err, (mute_ch < 0) ? 0 : 1);
        check({tag, "_nres"}, got_och.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < got_och.size()) begin
                check({tag, "_och"}, got_och[i], i);
                check({tag, "_data"}, got_data[i], resp[i]);
            end
        end
        check({tag, "_cycles"}, done_cyc - start_cyc + 1, exp_cyc);
        check({tag, "_fetches"}, fetch_cnt, n_pass);
        check({tag, "_clears"}, clr_cnt, n_pass);
        check({tag, "_issues"}, iss_cnt, n_pass);
        tick();
        check({tag, "_idle"}, bus.o_busy, 0);
        tick();
        tick();
        check({tag, "_one_done"}, done_cnt, 1);
    endtask

    initial begin
        reset = 1'b1;
        bus.i_start = 1'b0;
        randomize_data(1'b1);
        repeat (3) tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();

        // Nominal four-channel run, ready tied high.
        lat = 3; ready_mode = 0; mute_ch = -1; strays = 1'b0;
        start_run();
        wait_done();
        check("nominal_37", done_cyc - start_cyc + 1, 37);
        verify_run("nominal");

        // Output buffer stalls channel 1 for five cycles.
        randomize_data(1'b0);
        ready_mode = 2;
        start_run();
        wait_done();
        check("stall_cnt", stall_cnt, 5);
        verify_run("stall");

        // Accumulator silent on channel 2: timeout, sticky error.
        randomize_data(1'b0);
        ready_mode = 0; mute_ch = 2;
        start_run();
        wait_done();
        verify_run("timeout");
        repeat (5) tick();
        check("err_sticky", bus.o_err, 1);

        // Extra i_start while busy is ignored.
        randomize_data(1'b0);
        mute_ch = -1;
        start_run();
        repeat (10) tick();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_done();
        verify_run("busy_start");

        // Reset while waiting on channel 1, then restart.
        randomize_data(1'b0);
        start_run();
        begin
            int n = 0;
            while (iss_cnt < 2 && n < 200) begin
                tick();
                n++;
            end
        end
        check("rst_reach_ch1", iss_cnt, 2);
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("midrst");
        reset = 1'b0;
        repeat (8) tick();
        check("midrst_no_done", done_cnt, 0);
        check("midrst_nres", got_och.size(), 1);
        start_run();
        wait_done();
        verify_run("restart");

        // Randomized runs: latency, ready, stray valids and occasional timeouts.
        for (int r = 0; r < 10; r++) begin
            randomize_data(1'b0);
            lat        = $urandom_range(0, 6);
            ready_mode = 1;
            if ($urandom_range(0, 3) == 0) begin
                mute_ch = $urandom_range(0, OCH - 1);
                strays  = 1'b0;
            end else begin
                mute_ch = -1;
                strays  = 1'b1;
            end
            start_run();
            wait_done();
            verify_run("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cnn_och_sched.md
CNN_OCH_SCHED -- requirements
Module: cnn_och_sched

Interface
REQ-001 SHALL have parameter OCH, default 4: number of output channels sequenced per run.
REQ-002 SHALL have parameter OUT_W, default 288: accumulator result width, OX*OY*DATA_LEN.
REQ-003 SHALL have parameter WT_W, default 288: weight bundle width per output channel, ICH*KX*KY*DATA_LEN.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before error.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port i_start, input, 1: run request, sampled only in IDLE.
REQ-008 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port o_done, output, 1: one-cycle pulse at the end of a run.
REQ-010 SHALL have port o_err, output, 1: sticky timeout flag; cleared by reset or an accepted i_start.
REQ-011 SHALL have port o_wt_rd_en, output, 1: weight memory read strobe.
REQ-012 SHALL have port o_wt_rd_addr, output, clog2(OCH): weight address, equal to the current channel index.
REQ-013 SHALL have port i_wt_rd_data, input, WT_W: weight data, valid exactly 1 cycle after o_wt_rd_en.
REQ-014 SHALL have port o_acc_weight, output, WT_W: registered weight bundle driving the accumulator.
REQ-015 SHALL have port o_acc_soft_reset, output, 1: accumulator clear pulse.
REQ-016 SHALL have port o_acc_in_valid, output, 1: accumulator start pulse.
REQ-017 SHALL have port i_acc_ot_valid, input, 1: accumulator result valid.
REQ-018 SHALL have port i_acc_ci_acc, input, OUT_W: accumulator result.
REQ-019 SHALL have port o_ot_valid, output, 1: result valid toward the output buffer.
REQ-020 SHALL have port i_ot_ready, input, 1: output buffer ready.
REQ-021 SHALL have port o_ot_och, output, clog2(OCH): channel index of o_ot_data.
REQ-022 SHALL have port o_ot_data, output, OUT_W: registered result.

Function
REQ-023 SHALL use the FSM states IDLE, CLR, FETCH, LATCH, ISSUE, WAIT, OUT, DONE; each state lasts at least one cycle.
REQ-024 IDLE & i_start SHALL transition to CLR, set channel index to 0 and clear o_err; i_start SHALL be ignored in all other states.
REQ-025 CLR SHALL assert o_acc_soft_reset for exactly that one cycle, then go to FETCH.
REQ-026 FETCH SHALL assert o_wt_rd_en with o_wt_rd_addr equal to the index for one cycle, then go to LATCH.
REQ-027 LATCH SHALL register i_wt_rd_data into o_acc_weight, then go to ISSUE; o_acc_weight SHALL hold otherwise.
REQ-028 ISSUE SHALL assert o_acc_in_valid for exactly that one cycle, then go to WAIT with the timeout counter at 0.
REQ-029 WAIT with i_acc_ot_valid high SHALL register i_acc_ci_acc into o_ot_data and the index into o_ot_och, then go to OUT.
REQ-030 WAIT without valid SHALL increment the counter; at counter == TIMEOUT-1 without valid it SHALL set o_err and go to DONE, skipping the remaining channels.
REQ-031 i_acc_ot_valid SHALL be ignored outside WAIT.
REQ-032 OUT SHALL hold o_ot_valid high with o_ot_data and o_ot_och stable until i_ot_ready is high (handshake).
REQ-033 On handshake with index == OCH-1, OUT SHALL go to DONE; otherwise the index SHALL increment and the FSM SHALL go to CLR.
REQ-034 DONE SHALL pulse o_done for one cycle, then go to IDLE.
REQ-035 A run with no stall SHALL take 6+L cycles per channel (L = accumulator latency, from ISSUE to valid) plus 1 cycle for DONE.

Reset
REQ-036 reset SHALL take priority over every state: FSM to IDLE, index and counter to 0.
REQ-037 reset SHALL drive all outputs to 0, including o_acc_weight, o_ot_data and o_err.
REQ-038 Reset mid-run SHALL NOT pulse o_done and SHALL NOT emit further results.

Verification
REQ-039 OCH=4, accumulator model with L=3 returning data 0x10+idx, ready tied high -> o_ot_och 0,1,2,3 with data 0x10..0x13, one o_done, 37 cycles from IDLE exit to o_done.
REQ-040 Hold i_ot_ready low for 5 cycles on channel 1 -> o_ot_valid, o_ot_data and o_ot_och stable throughout; no CLR before the handshake.
REQ-041 Accumulator never responds on channel 2 -> o_err=1 after 64 WAIT cycles, o_done pulses, channel 3 is never fetched, o_err stays high until the next i_start.
REQ-042 Pulse i_start while o_busy -> no effect; the run completes normally.
REQ-043 Assert reset during WAIT of channel 1 -> the next cycle is IDLE with all outputs 0 and no o_done; a new i_start restarts at channel 0.
REQ-044 Check that o_wt_rd_addr equals the index in FETCH, and that o_acc_soft_reset and o_acc_in_valid are single-cycle pulses once per channel.
